lab6_mac_dpath: RTL and testbench

Parametrised weighted-sum datapath: accepts a burst of `N` signed operands on `din` over `N` consecutive clocks, starting with the cycle `irdy` is asserted. It computes `Y = sum(C_k * X_k) >>> SHIFT` using per-burst coefficients, with optional saturation. It returns `Y` with a one-cycle `ordy` pulse. It is the generalised successor of the fixed three-operand lab datapath, adding width, operand count, coefficients, scaling, saturation and back-to-back burst pipelining.

---
 rtl/lab6_mac_dpath.sv | 159 +++++++++++++++
 tb/tb_lab6_mac_dpath.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab6_mac_dpath.sv
// rtl/lab6_mac_dpath.sv - parametrised weighted-sum (MAC) datapath with saturation
//
// Collects a burst of N signed operands starting on the irdy cycle, forms
// Y = sum(C_k * X_k) >>> SHIFT through a product / accumulate / output
// pipeline, and presents Y with a one-cycle ordy pulse (latency N+2).
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-low reset
//   irdy   - start of burst; din holds X1 in this cycle
//   din    - signed operand X_k (W bits)
//   coef   - packed signed coefficients, C_k = coef[k*CW-1 : (k-1)*CW]
//   ordy   - one-cycle pulse when dout holds a new result
//   dout   - signed result (W bits), held between ordy pulses
//   ovf    - result was clamped (SAT=1) or wrapped (SAT=0); valid with ordy
//   busy   - high while X2..XN are being collected
`timescale 1ns/1ps

module lab6_mac_dpath #(
    parameter int W     = 10,
    parameter int N     = 3,
    parameter int CW    = 8,
    parameter int SHIFT = 0,
    parameter int SAT   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            irdy,
    input  logic [W-1:0]    din,
    input  logic [N*CW-1:0] coef,
    output logic            ordy,
    output logic [W-1:0]    dout,
    output logic            ovf,
    output logic            busy
);

    localparam int PW = W + CW;
    localparam int AW = PW + $clog2(N);
    localparam int KW = $clog2(N + 1);

    localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [W-1:0]         MAXW = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         MINW = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t              state, state_n;
    logic [KW-1:0]       cnt, cnt_n;
    logic [N*CW-1:0]     coef_q;
    logic                take, first, last;
    logic [CW-1:0]       csel;

    logic signed [PW-1:0] prod;
    logic                 p_vld, p_first, p_last;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] prod_x;
    logic                 a_done;

    logic signed [AW-1:0] r;
    logic                 fits;
    logic [W-1:0]         res;

    // Sequencer: X1 uses coef straight from the port (the irdy cycle), later
    // operands use the copy captured then, so coef may change mid-burst.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        take    = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        csel    = coef[CW-1:0];
        case (state)
            IDLE: begin
                if (irdy) begin
                    take    = 1'b1;
                    first   = 1'b1;
                    state_n = COLLECT;
                    cnt_n   = KW'(2);
                end
            end
            COLLECT: begin
                take = 1'b1;
                csel = coef_q[(int'(cnt) - 1) * CW +: CW];
                if (cnt == KW'(N)) begin
                    last    = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    assign busy = (state == COLLECT);

    // Sequencer state and S1 product register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            coef_q  <= '0;
            p_vld   <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            prod    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            if (state == IDLE && irdy)
                coef_q <= coef;
            p_vld   <= take;
            p_first <= first;
            p_last  <= last;
            if (take)
                prod <= $signed(din) * $signed(csel);
        end
    end

    assign prod_x = {{(AW-PW){prod[PW-1]}}, prod};

    // S2 accumulator: a first-tagged product reloads, so a following burst
    // can start right behind the previous one without a clear cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc    <= '0;
            a_done <= 1'b0;
        end else begin
            a_done <= p_vld & p_last;
            if (p_vld)
                acc <= p_first ? prod_x : acc + prod_x;
        end
    end

    // S3 scaling and range handling
    always_comb begin
        r    = acc >>> SHIFT;
        fits = (r >= MINV) && (r <= MAXV);
        res  = r[W-1:0];
        if (SAT != 0 && !fits)
            res = r[AW-1] ? MINW : MAXW;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ordy <= 1'b0;
            dout <= '0;
            ovf  <= 1'b0;
        end else begin
            ordy <= a_done;
            if (a_done) begin
                dout <= res;
                ovf  <= ~fits;
            end
        end
    end

endmodule

// File: tb/tb_lab6_mac_dpath.sv
// tb/tb_lab6_mac_dpath.sv - self-checking bench for lab6_mac_dpath
`timescale 1ns/1ps

module tb_lab6_mac_dpath;

    logic        clk = 1'b0;
    logic        reset;
    logic        irdy;
    logic [9:0]  din;
    logic [23:0] coef;

    logic        ordy_a, ovf_a, busy_a;
    logic [9:0]  dout_a;
    logic        ordy_s, ovf_s, busy_s;
    logic [9:0]  dout_s;
    logic        ordy_w, ovf_w, busy_w;
    logic [9:0]  dout_w;

    int n_pass  = 0;
    int n_total = 0;

    // expected {ovf, dout} per instance
    logic [10:0] q_a[$];
    logic [10:0] q_s[$];
    logic [10:0] q_w[$];

    always #5 clk = ~clk;

    lab6_mac_dpath #(.W(10), .N(3), .CW(8), .SHIFT(0), .SAT(1)) u_dut (
        .clk(clk), .reset(reset), .irdy(irdy), .din(din), .coef(coef),
        .ordy(ordy_a), .dout(dout_a), .ovf(ovf_a), .busy(busy_a)
    );

    lab6_mac_dpath #(.W(10), .N(3), .CW(8), .SHIFT(8), .SAT(1)) u_shift (
        .clk(clk), .reset(reset), .irdy(irdy), .din(din), .coef(coef),
        .ordy(ordy_s), .dout(dout_s), .ovf(ovf_s), .busy(busy_s)
    );

    lab6_mac_dpath #(.W(10), .N(3), .CW(8), .SHIFT(0), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .irdy(irdy), .din(din), .coef(coef),
        .ordy(ordy_w), .dout(dout_w), .ovf(ovf_w), .busy(busy_w)
    );

    function automatic logic [23:0] pk(input int c1, input int c2, input int c3);
        logic [7:0] a, b, c;
        a = c1[7:0];
        b = c2[7:0];
        c = c3[7:0];
        return {c, b, a};
    endfunction

    function automatic logic [10:0] ex(input int d, input logic o);
        logic [9:0] v;
        v = d[9:0];
        return {o, v};
    endfunction

    task automatic drive(input logic i, input int x, input logic [23:0] c);
        irdy = i;
        din  = x[9:0];
        coef = c;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 0, '0);
        repeat (3) @(negedge clk);
        n_total++; if (ordy_a !== 1'b0) $display("FAIL reset_ordy: got %b want 0", ordy_a); else n_pass++;
        n_total++; if (dout_a !== 10'd0) $display("FAIL reset_dout: got %0d want 0", $signed(dout_a)); else n_pass++;
        n_total++; if (ovf_a !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_a); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
        n_total++; if (dout_w !== 10'd0 || ordy_s !== 1'b0) $display("FAIL reset_other: dout_w=%0d ordy_s=%b want 0/0", $signed(dout_w), ordy_s); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [10:0] e;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_total++; if (ordy_a !== (i == 5)) $display("FAIL basic_ordy c%0d: got %b want %b", i, ordy_a, (i == 5)); else n_pass++;
            n_total++; if (busy_a !== (i == 1 || i == 2)) $display("FAIL basic_busy c%0d: got %b want %b", i, busy_a, (i == 1 || i == 2)); else n_pass++;
            if (ordy_a === 1'b1) begin
                if (q_a.size() == 0) begin
                    n_total++; $display("FAIL basic_extra: unexpected ordy in c%0d", i);
                end else begin
                    e = q_a.pop_front();
                    n_total++; if (dout_a !== e[9:0]) $display("FAIL basic_dout: got %0d want %0d", $signed(dout_a), $signed(e[9:0])); else n_pass++;
                    n_total++; if (ovf_a !== e[10]) $display("FAIL basic_ovf: got %b want %b", ovf_a, e[10]); else n_pass++;
                end
            end
            if (i > 5) begin
                n_total++; if (dout_a !== 10'd60) $display("FAIL basic_hold c%0d: got %0d want 60", i, $signed(dout_a)); else n_pass++;
            end
            case (i)
                0: begin drive(1'b1, 10, pk(1, 1, 1)); q_a.push_back(ex(60, 1'b0)); end
                1: drive(1'b0, 20, pk(1, 1, 1));
                2: drive(1'b0, 30, pk(1, 1, 1));
                default: drive(1'b0, 0, pk(1, 1, 1));
            endcase
        end
        n_total++; if (q_a.size() != 0) $display("FAIL basic_missing: %0d results never arrived", q_a.size()); else n_pass++;
        q_a.delete();
    endtask

    task automatic test_coef_change();
        logic [10:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_total++; if (ordy_a !== (i == 5)) $display("FAIL coef_ordy c%0d: got %b want %b", i, ordy_a, (i == 5)); else n_pass++;
            if (ordy_a === 1'b1 && q_a.size() != 0) begin
                e = q_a.pop_front();
                n_total++; if (dout_a !== e[9:0]) $display("FAIL coef_dout: got %0d want %0d", $signed(dout_a), $signed(e[9:0])); else n_pass++;
                n_total++; if (ovf_a !== e[10]) $display("FAIL coef_ovf: got %b want %b", ovf_a, e[10]); else n_pass++;
            end
            case (i)
                0: begin drive(1'b1, -5, pk(2, -3, 1)); q_a.push_back(ex(69, 1'b0)); end
                1: drive(1'b0, 7, '0);
                2: drive(1'b0, 100, '0);
                default: drive(1'b0, 0, '0);
            endcase
        end
        n_total++; if (q_a.size() != 0) $display("FAIL coef_missing: %0d results never arrived", q_a.size()); else n_pass++;
        q_a.delete();
    endtask

    task automatic test_saturation();
        logic [10:0] e;
        int x;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_total++; if (ordy_a !== (i == 5 || i == 8 || i == 11)) $display("FAIL sat_ordy c%0d: got %b", i, ordy_a); else n_pass++;
            if (ordy_a === 1'b1 && q_a.size() != 0) begin
                e = q_a.pop_front();
                n_total++; if (dout_a !== e[9:0] || ovf_a !== e[10]) $display("FAIL sat_main c%0d: got %0d/%b want %0d/%b", i, $signed(dout_a), ovf_a, $signed(e[9:0]), e[10]); else n_pass++;
            end
            if (ordy_s === 1'b1 && q_s.size() != 0) begin
                e = q_s.pop_front();
                n_total++; if (dout_s !== e[9:0] || ovf_s !== e[10]) $display("FAIL sat_shift c%0d: got %0d/%b want %0d/%b", i, $signed(dout_s), ovf_s, $signed(e[9:0]), e[10]); else n_pass++;
            end
            x = (i < 3) ? 511 : (i < 6) ? -512 : (i < 9) ? 100 : 0;
            drive((i % 3 == 0) && (i < 9), x, pk(100, 100, 100));
            if (i == 0) begin q_a.push_back(ex(511, 1'b1));  q_s.push_back(ex(511, 1'b1));  end
            if (i == 3) begin q_a.push_back(ex(-512, 1'b1)); q_s.push_back(ex(-512, 1'b1)); end
            if (i == 6) begin q_a.push_back(ex(511, 1'b1));  q_s.push_back(ex(117, 1'b0));  end
        end
        n_total++; if (q_a.size() != 0 || q_s.size() != 0) $display("FAIL sat_missing: %0d/%0d results never arrived", q_a.size(), q_s.size()); else n_pass++;
        q_a.delete();
        q_s.delete();
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_total++; if (ordy_a !== (i == 5 || i == 8)) $display("FAIL b2b_ordy c%0d: got %b", i, ordy_a); else n_pass++;
            n_total++; if (busy_a !== (i == 1 || i == 2 || i == 4 || i == 5)) $display("FAIL b2b_busy c%0d: got %b", i, busy_a); else n_pass++;
            if (ordy_a === 1'b1 && q_a.size() != 0) begin
                e = q_a.pop_front();
                n_total++; if (dout_a !== e[9:0] || ovf_a !== e[10]) $display("FAIL b2b_result c%0d: got %0d/%b want %0d/%b", i, $signed(dout_a), ovf_a, $signed(e[9:0]), e[10]); else n_pass++;
            end
            drive(i == 0 || i == 1 || i == 3, (i < 6) ? i + 1 : 0, pk(1, 1, 1));
            if (i == 0) q_a.push_back(ex(6, 1'b0));
            if (i == 3) q_a.push_back(ex(15, 1'b0));
        end
        n_total++; if (q_a.size() != 0) $display("FAIL b2b_missing: %0d results never arrived", q_a.size()); else n_pass++;
        q_a.delete();
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            n_total++; if (ordy_a !== (i == 9)) $display("FAIL rstmid_ordy c%0d: got %b want %b", i, ordy_a, (i == 9)); else n_pass++;
            if (i >= 3 && i <= 8) begin
                n_total++; if (dout_a !== 10'd0) $display("FAIL rstmid_dout c%0d: got %0d want 0", i, $signed(dout_a)); else n_pass++;
            end
            if (i == 3) begin
                n_total++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_a); else n_pass++;
            end
            if (ordy_a === 1'b1 && q_a.size() != 0) begin
                e = q_a.pop_front();
                n_total++; if (dout_a !== e[9:0] || ovf_a !== e[10]) $display("FAIL rstmid_result: got %0d/%b want %0d/%b", $signed(dout_a), ovf_a, $signed(e[9:0]), e[10]); else n_pass++;
            end
            reset = (i == 2) ? 1'b0 : 1'b1;
            case (i)
                0: drive(1'b1, 50, pk(1, 1, 1));
                1: drive(1'b0, 50, pk(1, 1, 1));
                4: begin drive(1'b1, 7, pk(1, 1, 1)); q_a.push_back(ex(21, 1'b0)); end
                5, 6: drive(1'b0, 7, pk(1, 1, 1));
                default: drive(1'b0, 0, pk(1, 1, 1));
            endcase
        end
        n_total++; if (q_a.size() != 0) $display("FAIL rstmid_missing: %0d results never arrived", q_a.size()); else n_pass++;
        q_a.delete();
    endtask

    task automatic test_wrap();
        logic [10:0] e;
        int xs[6] = '{511, 1, 0, -1, -1, -1};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_total++; if (ordy_w !== (i == 5 || i == 8)) $display("FAIL wrap_ordy c%0d: got %b", i, ordy_w); else n_pass++;
            if (ordy_w === 1'b1 && q_w.size() != 0) begin
                e = q_w.pop_front();
                n_total++; if (dout_w !== e[9:0] || ovf_w !== e[10]) $display("FAIL wrap_result c%0d: got %0d/%b want %0d/%b", i, $signed(dout_w), ovf_w, $signed(e[9:0]), e[10]); else n_pass++;
            end
            if (ordy_a === 1'b1 && q_a.size() != 0) begin
                e = q_a.pop_front();
                n_total++; if (dout_a !== e[9:0] || ovf_a !== e[10]) $display("FAIL wrap_satref c%0d: got %0d/%b want %0d/%b", i, $signed(dout_a), ovf_a, $signed(e[9:0]), e[10]); else n_pass++;
            end
            drive(i == 0 || i == 3, (i < 6) ? xs[i] : 0, pk(1, 1, 1));
            if (i == 0) begin q_w.push_back(ex(-512, 1'b1)); q_a.push_back(ex(511, 1'b1)); end
            if (i == 3) begin q_w.push_back(ex(-3, 1'b0));   q_a.push_back(ex(-3, 1'b0));  end
        end
        n_total++; if (q_w.size() != 0 || q_a.size() != 0) $display("FAIL wrap_missing: %0d/%0d results never arrived", q_w.size(), q_a.size()); else n_pass++;
        q_w.delete();
        q_a.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coef_change();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
